// File: rtl/contador_pop_pkg.sv
// contador_pop_pkg
//   Shared definitions for the FIFO read/push counters: state encodings of
//   the occupancy FSM and the default geometry (8 entries, 3-bit pointer).
package contador_pop_pkg;

  localparam int PROFUNDIDAD_DEF  = 8;
  localparam int ANCHO_CUENTA_DEF = 3;

  // Occupancy FSM encodings (2'b11 is unused).
  localparam logic [1:0] VACIO   = 2'b00;
  localparam logic [1:0] PARCIAL = 2'b01;
  localparam logic [1:0] LLENO   = 2'b10;

endpackage

// File: rtl/contador_mod.sv
// contador_mod
//   Modulo-PROFUNDIDAD counter with enable and synchronous active-high reset.
//   Shared by the push and pop counters.
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous reset, active high (count -> 0)
//   i_en       advance the count by one on this edge
//   o_cuenta   current count, 0..PROFUNDIDAD-1
module contador_mod
  import contador_pop_pkg::*;
#(
  parameter int PROFUNDIDAD  = PROFUNDIDAD_DEF,
  parameter int ANCHO_CUENTA = ANCHO_CUENTA_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  output logic [ANCHO_CUENTA-1:0] o_cuenta
);

  localparam logic [ANCHO_CUENTA-1:0] CUENTA_MAX = ANCHO_CUENTA'(PROFUNDIDAD - 1);
  localparam logic [ANCHO_CUENTA-1:0] CUENTA_UNO = ANCHO_CUENTA'(1);

  logic [ANCHO_CUENTA-1:0] r_cuenta;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_cuenta <= '0;
    else if (i_en)
      r_cuenta <= (r_cuenta == CUENTA_MAX) ? '0 : r_cuenta + CUENTA_UNO;
  end

  assign o_cuenta = r_cuenta;

endmodule

// File: rtl/contador_pop.sv
// contador_pop
//   Read-side counter of the 8-entry memory FIFO. Tracks occupancy from the
//   push and pop requests, keeps the read pointer, the empty/full flags, a
//   one-cycle accepted-pop pulse and a sticky underflow flag. All outputs
//   are registered.
// Ports:
//   i_clk              clock, rising edge
//   i_reset            synchronous reset, active high
//   i_push             write request (as seen by the push counter)
//   i_pop              read request from the consumer
//   o_cuenta_pop       read pointer, next entry to read
//   o_ocupacion        stored entries, 0..PROFUNDIDAD
//   o_vacio            occupancy is 0
//   o_lleno            occupancy is PROFUNDIDAD
//   o_pop_valido       high for the cycle after an accepted pop
//   o_error_underflow  sticky, set by a pop while empty
module contador_pop
  import contador_pop_pkg::*;
#(
  parameter int PROFUNDIDAD  = PROFUNDIDAD_DEF,
  parameter int ANCHO_CUENTA = ANCHO_CUENTA_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  output logic [ANCHO_CUENTA-1:0] o_cuenta_pop,
  output logic [ANCHO_CUENTA:0]   o_ocupacion,
  output logic                    o_vacio,
  output logic                    o_lleno,
  output logic                    o_pop_valido,
  output logic                    o_error_underflow
);

  localparam logic [ANCHO_CUENTA:0] OCUP_MAX = (ANCHO_CUENTA + 1)'(PROFUNDIDAD);
  localparam logic [ANCHO_CUENTA:0] OCUP_UNO = (ANCHO_CUENTA + 1)'(1);

  logic [1:0]            r_estado;
  logic [ANCHO_CUENTA:0] r_ocupacion;
  logic                  r_vacio;
  logic                  r_lleno;
  logic                  r_pop_valido;
  logic                  r_error_underflow;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [ANCHO_CUENTA:0] w_ocup_sig;
  logic [1:0]            w_estado_sig;

  // Acceptance depends only on the state at the sampling edge, so a push
  // into an empty FIFO never feeds a pop in the same cycle, and a pop out of
  // a full FIFO never makes room for a push in the same cycle.
  always_comb begin
    w_push_ok    = i_push && (r_estado != LLENO);
    w_pop_ok     = i_pop  && (r_estado != VACIO);
    w_ocup_sig   = r_ocupacion;
    if (w_push_ok && !w_pop_ok)
      w_ocup_sig = r_ocupacion + OCUP_UNO;
    else if (!w_push_ok && w_pop_ok)
      w_ocup_sig = r_ocupacion - OCUP_UNO;
    w_estado_sig = PARCIAL;
    if (w_ocup_sig == '0)
      w_estado_sig = VACIO;
    else if (w_ocup_sig == OCUP_MAX)
      w_estado_sig = LLENO;
  end

  // Flags are registered from the next occupancy so they line up with
  // o_ocupacion on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_estado          <= VACIO;
      r_ocupacion       <= '0;
      r_vacio           <= 1'b1;
      r_lleno           <= 1'b0;
      r_pop_valido      <= 1'b0;
      r_error_underflow <= 1'b0;
    end else begin
      r_estado     <= w_estado_sig;
      r_ocupacion  <= w_ocup_sig;
      r_vacio      <= (w_estado_sig == VACIO);
      r_lleno      <= (w_estado_sig == LLENO);
      r_pop_valido <= w_pop_ok;
      if (i_pop && (r_estado == VACIO))
        r_error_underflow <= 1'b1;
    end
  end

  contador_mod #(
    .PROFUNDIDAD  (PROFUNDIDAD),
    .ANCHO_CUENTA (ANCHO_CUENTA)
  ) u_cuenta_pop (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (w_pop_ok),
    .o_cuenta (o_cuenta_pop)
  );

  assign o_ocupacion       = r_ocupacion;
  assign o_vacio           = r_vacio;
  assign o_lleno           = r_lleno;
  assign o_pop_valido      = r_pop_valido;
  assign o_error_underflow = r_error_underflow;

endmodule

// File: tb/tb_contador_pop.sv
// Scoreboard bench for contador_pop: the driver applies one request per
// cycle, steps an arithmetic reference model and queues the expected
// outputs; a monitor compares every cycle after the edge.
module tb_contador_pop;

  localparam int PROF = 8;

  typedef struct {
    int ptr;
    int occ;
    bit vac;
    bit lle;
    bit pv;
    bit err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [2:0] cuenta_pop;
  logic [3:0] ocupacion;
  logic       vacio, lleno, pop_valido, error_underflow;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   done = 0;

  // reference model state
  int m_occ = 0;
  int m_ptr = 0;
  bit m_err = 0;

  contador_pop #(.PROFUNDIDAD(8), .ANCHO_CUENTA(3)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_push            (push),
    .i_pop             (pop),
    .o_cuenta_pop      (cuenta_pop),
    .o_ocupacion       (ocupacion),
    .o_vacio           (vacio),
    .o_lleno           (lleno),
    .o_pop_valido      (pop_valido),
    .o_error_underflow (error_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // One request per edge: drive off the edge, then queue the model result.
  task automatic cyc(input bit r, input bit pu, input bit po);
    exp_t e;
    bit pok;
    bit puk;
    @(negedge clk);
    reset = r;
    push  = pu;
    pop   = po;
    if (r) begin
      m_occ = 0; m_ptr = 0; m_err = 0; pok = 0;
    end else begin
      pok = po && (m_occ > 0);
      puk = pu && (m_occ < PROF);
      if (po && m_occ == 0) m_err = 1;
      m_occ = m_occ + int'(puk) - int'(pok);
      if (pok) m_ptr = (m_ptr + 1) % PROF;
    end
    e.ptr = m_ptr; e.occ = m_occ;
    e.vac = (m_occ == 0); e.lle = (m_occ == PROF);
    e.pv = pok; e.err = m_err;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cuenta_pop", int'(cuenta_pop), e.ptr);
        chk("ocupacion", int'(ocupacion), e.occ);
        chk("vacio", int'(vacio), int'(e.vac));
        chk("lleno", int'(lleno), int'(e.lle));
        chk("pop_valido", int'(pop_valido), int'(e.pv));
        chk("error_underflow", int'(error_underflow), int'(e.err));
      end
    end
  end

  initial begin : driver
    int budget;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    // fill, then drain across the pointer wrap
    repeat (8) cyc(0, 1, 0);
    cyc(0, 1, 0);                 // push into LLENO: ignored, no error
    repeat (8) cyc(0, 0, 1);
    // underflow, then a push with the error still set
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    // occupancy 3 with simultaneous push+pop
    cyc(1, 0, 0);
    repeat (3) cyc(0, 1, 0);
    repeat (4) cyc(0, 1, 1);
    // fill then push+pop while full
    repeat (5) cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    // empty + push + pop together: pop rejected, push counted
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    // reset during a pop at occupancy 5, then pop after release
    cyc(1, 0, 0);
    repeat (5) cyc(0, 1, 0);
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    // random traffic, biased in phases toward filling and draining
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 60) % 2 == 0) ? 70 : 30;
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < bias),
          ($urandom_range(0, 99) < 100 - bias));
    end
    cyc(0, 0, 0);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
